// File: rtl/tlb_req_arbiter.sv
// rtl/tlb_req_arbiter.sv - round-robin TLB lookup arbiter with page-walk fill sequencing
// Optional walk watchdog: define TLB_ARB_WATCHDOG_EN.
module tlb_req_arbiter #(
  parameter int SADDR   = 64,
  parameter int SPAGE   = 12,
  parameter int SPCID   = 12,
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ*SADDR-1:0]     req_va,
  input  logic [NREQ*SPCID-1:0]     req_pcid,
  output logic [NREQ-1:0]           req_ready,
  output logic                      resp_valid,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [SADDR-1:0]          resp_ta,
  output logic                      resp_fault,
  output logic                      tlb_lookup,
  output logic [SADDR-1:0]          tlb_va,
  output logic [SPCID-1:0]          tlb_pcid,
  input  logic                      tlb_hit,
  input  logic                      tlb_miss,
  input  logic [SADDR-1:0]          tlb_ta,
  output logic                      tlb_fill,
  output logic [SADDR-1:0]          tlb_fill_pa,
  output logic                      walk_req,
  output logic [SADDR-1:0]          walk_va,
  input  logic                      walk_ack,
  input  logic [SADDR-1:0]          walk_pa,
  input  logic                      walk_fault
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WAIT,
    S_WALK,
    S_FILL,
    S_RESP
  } state_t;

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_found;

`ifdef TLB_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0]   walk_cnt;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // The walker page offset is replaced by the request offset, so its low bits are don't-care.
  logic unused_walk_pa_low;
  assign unused_walk_pa_low = ^walk_pa[SPAGE-1:0];

  // Scan from the requester after the last winner so a held request waits at most NREQ grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign req_ready = (state == S_IDLE && gnt_found) ? (NREQ'(1) << gnt_idx) : '0;
  assign walk_va   = tlb_va;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= IW'(NREQ - 1);
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_ta     <= '0;
      resp_fault  <= 1'b0;
      tlb_lookup  <= 1'b0;
      tlb_va      <= '0;
      tlb_pcid    <= '0;
      tlb_fill    <= 1'b0;
      tlb_fill_pa <= '0;
      walk_req    <= 1'b0;
`ifdef TLB_ARB_WATCHDOG_EN
      walk_cnt    <= '0;
`endif
    end else begin
      tlb_lookup <= 1'b0;
      tlb_fill   <= 1'b0;
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            ptr        <= gnt_idx;
            resp_id    <= gnt_idx;
            tlb_va     <= req_va[gnt_idx*SADDR +: SADDR];
            tlb_pcid   <= req_pcid[gnt_idx*SPCID +: SPCID];
            resp_fault <= 1'b0;
            tlb_lookup <= 1'b1;
            state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A simultaneous hit and miss is resolved as a hit.
          if (tlb_hit) begin
            resp_ta    <= tlb_ta;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else if (tlb_miss) begin
            walk_req <= 1'b1;
`ifdef TLB_ARB_WATCHDOG_EN
            walk_cnt <= '0;
`endif
            state    <= S_WALK;
          end
        end
        S_WALK: begin
          if (walk_ack) begin
            walk_req <= 1'b0;
            if (walk_fault) begin
              resp_fault <= 1'b1;
              resp_ta    <= '0;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              resp_ta     <= {walk_pa[SADDR-1:SPAGE], tlb_va[SPAGE-1:0]};
              tlb_fill_pa <= {walk_pa[SADDR-1:SPAGE], {SPAGE{1'b0}}};
              tlb_fill    <= 1'b1;
              state       <= S_FILL;
            end
          end
`ifdef TLB_ARB_WATCHDOG_EN
          // Count reaching TIMEOUT means TIMEOUT WALK cycles elapsed with no answer.
          else if (walk_cnt == CW'(TIMEOUT - 1)) begin
            walk_req   <= 1'b0;
            resp_fault <= 1'b1;
            resp_ta    <= '0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            walk_cnt <= walk_cnt + CW'(1);
          end
`endif
        end
        S_FILL: begin
          resp_valid <= 1'b1;
          state      <= S_RESP;
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_req_arbiter.sv
// tb/tb_tlb_req_arbiter.sv - randomized self-checking bench for tlb_req_arbiter
// Honours TLB_ARB_WATCHDOG_EN when the design is built with it.
module tb_tlb_req_arbiter;
  localparam int SADDR   = 64;
  localparam int SPAGE   = 12;
  localparam int SPCID   = 12;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;

  logic                    clk;
  logic                    rst;
  logic [NREQ-1:0]         req_valid;
  logic [NREQ*SADDR-1:0]   req_va;
  logic [NREQ*SPCID-1:0]   req_pcid;
  logic [NREQ-1:0]         req_ready;
  logic                    resp_valid;
  logic [$clog2(NREQ)-1:0] resp_id;
  logic [SADDR-1:0]        resp_ta;
  logic                    resp_fault;
  logic                    tlb_lookup;
  logic [SADDR-1:0]        tlb_va;
  logic [SPCID-1:0]        tlb_pcid;
  logic                    tlb_hit;
  logic                    tlb_miss;
  logic [SADDR-1:0]        tlb_ta;
  logic                    tlb_fill;
  logic [SADDR-1:0]        tlb_fill_pa;
  logic                    walk_req;
  logic [SADDR-1:0]        walk_va;
  logic                    walk_ack;
  logic [SADDR-1:0]        walk_pa;
  logic                    walk_fault;

  tlb_req_arbiter #(
    .SADDR(SADDR), .SPAGE(SPAGE), .SPCID(SPCID), .NREQ(NREQ), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_va(req_va), .req_pcid(req_pcid), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_ta(resp_ta), .resp_fault(resp_fault),
    .tlb_lookup(tlb_lookup), .tlb_va(tlb_va), .tlb_pcid(tlb_pcid),
    .tlb_hit(tlb_hit), .tlb_miss(tlb_miss), .tlb_ta(tlb_ta),
    .tlb_fill(tlb_fill), .tlb_fill_pa(tlb_fill_pa),
    .walk_req(walk_req), .walk_va(walk_va), .walk_ack(walk_ack),
    .walk_pa(walk_pa), .walk_fault(walk_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int last     = NREQ - 1;
  int exp_resp = 0;
  int exp_fill = 0;
  int mon_resp = 0;
  int mon_fill = 0;
  logic [SADDR-1:0] va_tab   [NREQ];
  logic [SPCID-1:0] pcid_tab [NREQ];

  always @(posedge clk) begin
    if (!rst) begin
      if (resp_valid) mon_resp <= mon_resp + 1;
      if (tlb_fill)   mon_fill <= mon_fill + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requested index after the previous winner.
  function automatic int model_grant(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int c = (last + k) % NREQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic load_reqs();
    for (int i = 0; i < NREQ; i++) begin
      req_va[i*SADDR +: SADDR]   = va_tab[i];
      req_pcid[i*SPCID +: SPCID] = pcid_tab[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    last = NREQ - 1;
  endtask

  // mode: 0 hit, 1 miss then good walk, 2 miss then faulting walk, 3 hit+miss together
  task automatic run_txn(input logic [NREQ-1:0] mask, input int mode, input int d, input int wl,
                         input logic [63:0] ta_in, input logic [63:0] pa_in);
    int g;
    logic [63:0] exp_pa;
    logic [63:0] exp_ta;
    g = model_grant(mask);
    load_reqs();
    req_valid = mask;
    #1;
    check_eq("req_ready", 64'(req_ready), 64'(1) << g);
    last = g;
    step();
    req_valid = '0;
    check_eq("tlb_lookup", 64'(tlb_lookup), 64'(1));
    check_eq("tlb_va", tlb_va, va_tab[g]);
    check_eq("tlb_pcid", 64'(tlb_pcid), 64'(pcid_tab[g]));
    step();
    check_eq("lookup_pulse", 64'(tlb_lookup), 64'(0));
    for (int i = 0; i < d; i++) begin
      step();
      check_eq("early_resp", 64'(resp_valid), 64'(0));
    end
    tlb_hit  = (mode == 0 || mode == 3);
    tlb_miss = (mode != 0);
    tlb_ta   = ta_in;
    step();
    tlb_hit  = 1'b0;
    tlb_miss = 1'b0;
    if (mode == 0 || mode == 3) begin
      check_eq("hit_resp_valid", 64'(resp_valid), 64'(1));
      check_eq("hit_resp_id", 64'(resp_id), 64'(g));
      check_eq("hit_resp_ta", resp_ta, ta_in);
      check_eq("hit_resp_fault", 64'(resp_fault), 64'(0));
      check_eq("hit_no_walk", 64'(walk_req), 64'(0));
      exp_resp++;
    end else begin
      check_eq("walk_req_rise", 64'(walk_req), 64'(1));
      check_eq("walk_va", walk_va, va_tab[g]);
      for (int i = 0; i < wl; i++) begin
        step();
        check_eq("walk_req_hold", 64'(walk_req), 64'(1));
      end
      walk_ack   = 1'b1;
      walk_pa    = pa_in;
      walk_fault = (mode == 2);
      step();
      walk_ack   = 1'b0;
      walk_fault = 1'b0;
      check_eq("walk_req_drop", 64'(walk_req), 64'(0));
      if (mode == 2) begin
        check_eq("flt_resp_valid", 64'(resp_valid), 64'(1));
        check_eq("flt_resp_id", 64'(resp_id), 64'(g));
        check_eq("flt_resp_fault", 64'(resp_fault), 64'(1));
        check_eq("flt_resp_ta", resp_ta, 64'(0));
        check_eq("flt_no_fill", 64'(tlb_fill), 64'(0));
        exp_resp++;
      end else begin
        exp_pa = pa_in & ~64'hfff;
        exp_ta = exp_pa | (va_tab[g] & 64'hfff);
        check_eq("fill_pulse", 64'(tlb_fill), 64'(1));
        check_eq("fill_pa", tlb_fill_pa, exp_pa);
        exp_fill++;
        step();
        check_eq("miss_resp_valid", 64'(resp_valid), 64'(1));
        check_eq("miss_resp_id", 64'(resp_id), 64'(g));
        check_eq("miss_resp_ta", resp_ta, exp_ta);
        check_eq("miss_resp_fault", 64'(resp_fault), 64'(0));
        check_eq("fill_once", 64'(tlb_fill), 64'(0));
        exp_resp++;
      end
    end
    step();
    check_eq("resp_pulse", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    int seen;
    rst = 1'b1;
    req_valid = '0; req_va = '0; req_pcid = '0;
    tlb_hit = 1'b0; tlb_miss = 1'b0; tlb_ta = '0;
    walk_ack = 1'b0; walk_pa = '0; walk_fault = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      va_tab[i] = '0;
      pcid_tab[i] = '0;
    end
    repeat (3) step();
    rst = 1'b0;
    last = NREQ - 1;
    #1;
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    check_eq("rst_resp_valid", 64'(resp_valid), 64'(0));
    check_eq("rst_lookup", 64'(tlb_lookup), 64'(0));
    check_eq("rst_fill", 64'(tlb_fill), 64'(0));
    check_eq("rst_walk_req", 64'(walk_req), 64'(0));
    check_eq("rst_resp_ta", resp_ta, 64'(0));
    check_eq("rst_resp_id", 64'(resp_id), 64'(0));
    check_eq("rst_resp_fault", 64'(resp_fault), 64'(0));
    check_eq("rst_tlb_va", tlb_va, 64'(0));
    check_eq("rst_tlb_pcid", 64'(tlb_pcid), 64'(0));

    va_tab[0] = 64'h1000_0abc; pcid_tab[0] = 12'h011;
    va_tab[1] = 64'h2000_0def; pcid_tab[1] = 12'h022;
    run_txn(2'b11, 0, 0, 0, 64'h5000_0abc, 64'h0);
    run_txn(2'b11, 0, 1, 0, 64'h6000_0def, 64'h0);

    va_tab[0] = 64'h1234_5678;
    run_txn(2'b01, 1, 0, 5, 64'h0, 64'h0000_7000);
    run_txn(2'b10, 2, 2, 3, 64'h0, 64'h0000_9000);

    for (int i = 0; i < 8; i++)
      run_txn(2'b11, i % 3, 0, 1, {$urandom, $urandom}, {$urandom, $urandom});

    // Reset while the walk is outstanding, then a stale walk_ack in IDLE.
    va_tab[1] = 64'h3333_4444;
    load_reqs();
    req_valid = 2'b10;
    step();
    req_valid = '0;
    step();
    tlb_miss = 1'b1;
    step();
    tlb_miss = 1'b0;
    check_eq("rw_walk_req", 64'(walk_req), 64'(1));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last = NREQ - 1;
    check_eq("rw_walk_drop", 64'(walk_req), 64'(0));
    check_eq("rw_no_resp", 64'(resp_valid), 64'(0));
    walk_ack = 1'b1;
    walk_pa  = 64'h00ab_c000;
    step();
    walk_ack = 1'b0;
    check_eq("late_ack_resp", 64'(resp_valid), 64'(0));
    check_eq("late_ack_fill", 64'(tlb_fill), 64'(0));
    check_eq("late_ack_walk", 64'(walk_req), 64'(0));
    run_txn(2'b11, 1, 0, 2, 64'h0, 64'h0004_2000);

    // Silent walker.
    va_tab[0] = 64'h0bad_0123;
    load_reqs();
    req_valid = 2'b01;
    step();
    req_valid = '0;
    last = 0;
    step();
    tlb_miss = 1'b1;
    step();
    tlb_miss = 1'b0;
    check_eq("wd_walk_req", 64'(walk_req), 64'(1));
    seen = 0;
`ifdef TLB_ARB_WATCHDOG_EN
    for (int i = 1; i < TIMEOUT; i++) begin
      step();
      if (resp_valid) seen++;
    end
    check_eq("wd_early_resp", 64'(seen), 64'(0));
    step();
    check_eq("wd_resp_valid", 64'(resp_valid), 64'(1));
    check_eq("wd_resp_fault", 64'(resp_fault), 64'(1));
    check_eq("wd_resp_ta", resp_ta, 64'(0));
    check_eq("wd_walk_drop", 64'(walk_req), 64'(0));
    exp_resp++;
    step();
`else
    for (int i = 0; i < 1000; i++) begin
      step();
      if (resp_valid) seen++;
    end
    check_eq("nowd_no_resp", 64'(seen), 64'(0));
    check_eq("nowd_walk_held", 64'(walk_req), 64'(1));
    do_reset();
`endif

    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        va_tab[i]   = {$urandom, $urandom};
        pcid_tab[i] = SPCID'($urandom);
      end
      run_txn(NREQ'($urandom_range(1, (1 << NREQ) - 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              {$urandom, $urandom}, {$urandom, $urandom});
    end

    step();
    check_eq("resp_count", 64'(mon_resp), 64'(exp_resp));
    check_eq("fill_count", 64'(mon_fill), 64'(exp_fill));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tlb_req_arbiter.md
# tlb_req_arbiter

Sequencing controller in front of the set-associative TLB cache. It shares the single TLB lookup port between NREQ requesters (fetch, load/store, ...) with round-robin arbitration and runs each lookup to completion. On a TLB miss it issues a page-walk request, fills the TLB with the returned translation, and returns the translated address to the winning requester. Only one translation is in flight at a time.

## Interface
- SADDR, 64, address width
- SPAGE, 12, page-offset width
- SPCID, 12, process-context identifier width
- NREQ, 2, number of requesters (≥2)
- TIMEOUT, 255, walk watchdog limit in cycles (used only with the watchdog macro)

- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  requester i has a request; held until accepted
- req_va  in  NREQ*SADDR  virtual address, requester i at [i*SADDR +: SADDR]
- req_pcid  in  NREQ*SPCID  pcid, requester i at [i*SPCID +: SPCID]
- req_ready  out  NREQ  one-hot, 1-cycle accept pulse
- resp_valid  out  1  1-cycle response pulse
- resp_id  out  $clog2(NREQ)  requester index of the response
- resp_ta  out  SADDR  translated address
- resp_fault  out  1  walk failed; resp_ta is 0
- tlb_lookup  out  1  1-cycle lookup strobe to the TLB
- tlb_va  out  SADDR  latched request va, stable from strobe until return to IDLE
- tlb_pcid  out  SPCID  latched request pcid, same stability as tlb_va
- tlb_hit  in  1  TLB hit pulse
- tlb_miss  in  1  TLB miss pulse
- tlb_ta  in  SADDR  TLB translated address, valid with tlb_hit
- tlb_fill  out  1  1-cycle fill strobe
- tlb_fill_pa  out  SADDR  physical address to insert, page-aligned (low SPAGE bits 0)
- walk_req  out  1  page-walk request, level held until walk_ack
- walk_va  out  SADDR  equals tlb_va
- walk_ack  in  1  walker done pulse
- walk_pa  in  SADDR  walker physical page address, valid with walk_ack
- walk_fault  in  1  walker fault, valid with walk_ack

## Operation
- States: IDLE, LOOKUP, WAIT, WALK, FILL, RESP.
- IDLE: if any req_valid, grant the first valid index scanning from ptr+1 modulo NREQ. Pulse req_ready[g], latch va, pcid, and id=g, set ptr=g, go to LOOKUP. With no request, stay in IDLE.
- LOOKUP: tlb_lookup=1 for one cycle, then go to WAIT.
- WAIT: on tlb_hit, latch tlb_ta into resp_ta and go to RESP. On tlb_miss, go to WALK. tlb_hit and tlb_miss in the same cycle count as a hit.
- WALK: walk_req=1. On walk_ack with walk_fault=0, latch {walk_pa[SADDR-1:SPAGE], va[SPAGE-1:0]} as resp_ta and go to FILL. On walk_ack with walk_fault=1, set resp_fault=1, resp_ta=0, and go to RESP without a fill.
- FILL: tlb_fill=1 for one cycle, tlb_fill_pa={walk_pa[SADDR-1:SPAGE], SPAGE'b0}. Go to RESP.
- RESP: resp_valid=1 for one cycle with resp_id, resp_ta, resp_fault. Go to IDLE.
- A TLB hit never touches the walker. A fault never fills the TLB.
- Reset values: state=IDLE, ptr=NREQ-1 (requester 0 wins first), all strobes and pulses 0, walk_req=0, resp_ta=0, resp_id=0, resp_fault=0, tlb_va=0, tlb_pcid=0.
- Reset mid-operation: abandons the transaction and drops walk_req the next cycle. No response is issued. A late walk_ack arriving in IDLE is ignored.
- tlb_hit, tlb_miss and walk_ack are ignored outside WAIT and WALK respectively.

## Timing
- The accept pulse occurs in the IDLE cycle. The lookup strobe comes 1 cycle after accept.
- Hit path: accept at cycle 0 and lookup at 1. With a hit at cycle k≥2, resp_valid is at k+1.
- Miss path: with the miss at cycle k, walk_req rises at k+1. With walk_ack at cycle w, tlb_fill is at w+1 and resp_valid at w+2.
- Minimum hit-path request-to-request spacing is 4 cycles, for a TLB answering the cycle after the strobe.
- Arbitration is fair: a requester held valid is granted within NREQ transactions.

## Configuration
- TLB_ARB_WATCHDOG_EN defined: a walk counter clears on entry to WALK and increments each WALK cycle. When the count reaches TIMEOUT without walk_ack, walk_req drops, resp_fault=1 and resp_ta=0, and the FSM goes to RESP.
- Not defined: WALK waits indefinitely and the counter is absent.

## Test plan
- After reset, with req_valid=2'b11, va0=0x1000_0abc and a TLB hit with tlb_ta=0x5000_0abc: req_ready=2'b01 at cycle 0, resp_valid with id 0 and ta 0x5000_0abc at cycle 3. Requester 1 is granted next.
- Miss with walk_ack at 5 cycles after walk_req, walk_pa=0x0000_7000, va=0x1234_5678: tlb_fill_pa=0x7000, then resp_ta=0x7678, resp_fault=0.
- Walk fault: no tlb_fill pulse, resp_fault=1, resp_ta=0.
- Both requesters held valid for 8 transactions: grants alternate 0,1,0,1,…
- rst asserted during WALK: walk_req is 0 the next cycle and no resp_valid. A later walk_ack is ignored. The next request completes normally.
- TLB_ARB_WATCHDOG_EN with TIMEOUT=16 and the walker silent: resp_valid with fault=1 exactly 16 WALK cycles after walk_req rises. Without the macro, no response occurs within 1000 cycles.
